demux_1_2_buffer: RTL
=====================

# demux_1_2_buffer

Write-back routing block: the inverse of the write-back 2:1 select. It accepts one 32-bit result stream, steers each word to destination A or B under `controle`, and buffers it in a small per-destination FIFO with valid/ready handshakes on every side. It sits between the write-back stage and two consumers, for example the register-file write port and a forwarding/trace sink, so that either consumer can stall without corrupting the other's stream.

## Interface
- `LARGURA`, 32, data width in bits
- `PROFUNDIDADE`, 2, entries per destination FIFO; power of two, ≥2
- `clock` input 1, single clock, all state on rising edge
- `reset` input 1, asynchronous, active-high
- `entrada` input LARGURA, word to route
- `controle` input 1, 0 routes to A, 1 routes to B; sampled with `entrada`
- `entrada_valida` input 1, producer offers `entrada`
- `entrada_pronta` output 1, block accepts this cycle
- `saidaA`, `saidaB` output LARGURA, head word of each FIFO
- `saidaA_valida`, `saidaB_valida` output 1, FIFO non-empty
- `saidaA_pronta`, `saidaB_pronta` input 1, consumer takes head
- `ocupacaoA`, `ocupacaoB` output $clog2(PROFUNDIDADE)+1, entries held

## Operation
- Two independent FIFOs, A and B. Each FIFO has storage, a read pointer, a write pointer (each $clog2(PROFUNDIDADE) bits, wrapping modulo PROFUNDIDADE), and an occupancy counter.
- `entrada_pronta` is a combinational function of `controle` and FIFO state: it is 1 when `controle`=0 and FIFO A is not full, or when `controle`=1 and FIFO B is not full.
- Push: when `entrada_valida` & `entrada_pronta`, `entrada` is written at the write pointer of the selected FIFO. That FIFO's write pointer advances and its occupancy increments. The other FIFO is untouched.
- Pop: when `saidaX_valida` & `saidaX_pronta`, the read pointer of X advances and occupancy decrements.
- Push and pop on the same FIFO in the same cycle: occupancy is unchanged and both pointers advance.
- When the selected FIFO is full, the push is refused even if a pop happens on that FIFO in the same cycle. There is no same-cycle bypass.
- Push to one FIFO and pop from the other in the same cycle are fully independent.
- `saidaX` = storage[read pointer]. `saidaX_valida` = (ocupacaoX != 0).
- Pop while empty is ignored: no pointer or counter change and no underflow.
- Word order is preserved per destination. There is no ordering relation between A and B.
- Producer rule: `entrada` and `controle` must be held stable while `entrada_valida`=1 and `entrada_pronta`=0. The bench flags violations, but the block needs no protection against them.

## Timing
- Reset, asynchronous: all pointers and counters go to 0 and all storage is cleared to 0. Consequently `saidaA`=`saidaB`=0, `saidaA_valida`=`saidaB_valida`=0, and `ocupacaoA`=`ocupacaoB`=0. `entrada_pronta` is 1 for either `controle` value.
- Reset asserted mid-operation discards all buffered words immediately, without waiting for a clock edge.
- Latency: a word accepted at edge N appears on `saidaX` with `saidaX_valida`=1 after edge N, so it can be popped at edge N+1.
- Throughput: one push per cycle and one pop per destination per cycle. Sustained 1 word/cycle per destination when the consumer is always ready.
- Full: ocupacaoX = PROFUNDIDADE. `entrada_pronta`=0 only while `controle` selects X.
- Wrap-around: pointers roll from PROFUNDIDADE-1 to 0 with no bubble.

## Test plan
- Reset then idle: assert `reset` mid-cycle. All outputs are 0 at once, and `entrada_pronta`=1 for `controle`=0 and for `controle`=1.
- Alternating routing: push 0x11111111 (c=0), 0x22222222 (c=1), 0x33333333 (c=0) with both consumers ready. A emits 0x11111111 then 0x33333333. B emits 0x22222222. Each word is valid one cycle after its push.
- Fill and backpressure: `saidaA_pronta`=0, push 0xA0, 0xA1 to A. Then `ocupacaoA`=2, and `entrada_pronta`=0 for c=0 but 1 for c=1. Pushing 0xB0 to B succeeds.
- Full plus pop, no bypass: A full, `saidaA_pronta`=1, offer 0xA2 to A. The pop of 0xA0 occurs and the push is refused. Next cycle 0xA2 is accepted, and A drains in order 0xA1, 0xA2.
- Wrap-around streaming: 10 consecutive pushes 0..9 to B with B always ready. Output is 0..9 in order with no gaps, and `ocupacaoB` stays ≤1.
- Reset mid-stream: A holds 2 words and B holds 1 when `reset` pulses. Both are empty immediately. The first post-reset push 0x55 to A appears at the head with `ocupacaoA`=1.

Source files
------------

// File: rtl/demux_1_2_buffer_if.sv
// Handshake bundle for the 1:2 write-back router: one producer stream in, two buffered
// consumer streams out. slave is the router's view, master is the producer/consumer side.
interface demux_1_2_buffer_if #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 2
);
  localparam int CW = $clog2(PROFUNDIDADE) + 1;

  logic [LARGURA-1:0] entrada;
  logic               controle;
  logic               entrada_valida;
  logic               entrada_pronta;

  logic [LARGURA-1:0] saidaA;
  logic               saidaA_valida;
  logic               saidaA_pronta;
  logic [CW-1:0]      ocupacaoA;

  logic [LARGURA-1:0] saidaB;
  logic               saidaB_valida;
  logic               saidaB_pronta;
  logic [CW-1:0]      ocupacaoB;

  modport slave (
    input  entrada, controle, entrada_valida, saidaA_pronta, saidaB_pronta,
    output entrada_pronta, saidaA, saidaA_valida, ocupacaoA,
           saidaB, saidaB_valida, ocupacaoB
  );

  modport master (
    output entrada, controle, entrada_valida, saidaA_pronta, saidaB_pronta,
    input  entrada_pronta, saidaA, saidaA_valida, ocupacaoA,
           saidaB, saidaB_valida, ocupacaoB
  );
endinterface

// File: rtl/demux_1_2_buffer.sv
// Routes each word to FIFO A (controle=0) or B (controle=1); word visible one edge after accept.
// Input stalls only when the selected FIFO is full (no pop bypass); each output stalls independently.
module demux_1_2_buffer #(
  parameter int LARGURA      = 32,
  parameter int PROFUNDIDADE = 2
) (
  input logic                 clock,
  input logic                 reset,
  demux_1_2_buffer_if.slave   bus
);
  localparam int PW = $clog2(PROFUNDIDADE);
  localparam int CW = PW + 1;

  logic [LARGURA-1:0] mem_q [2][PROFUNDIDADE];
  logic [PW-1:0]      rd_q  [2];
  logic [PW-1:0]      rd_d  [2];
  logic [PW-1:0]      wr_q  [2];
  logic [PW-1:0]      wr_d  [2];
  logic [CW-1:0]      cnt_q [2];
  logic [CW-1:0]      cnt_d [2];

  logic [1:0] cheio;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] pronta_saida;

  assign pronta_saida = {bus.saidaB_pronta, bus.saidaA_pronta};

  // Index 0 is destination A, index 1 is destination B.
  always_comb begin
    for (int x = 0; x < 2; x++) begin
      cheio[x] = (cnt_q[x] == CW'(PROFUNDIDADE));
      push[x]  = bus.entrada_valida && !cheio[x] && (bus.controle == 1'(x));
      pop[x]   = (cnt_q[x] != '0) && pronta_saida[x];
      rd_d[x]  = rd_q[x] + PW'(pop[x]);
      wr_d[x]  = wr_q[x] + PW'(push[x]);
      cnt_d[x] = cnt_q[x] + CW'(push[x]) - CW'(pop[x]);
    end
  end

  assign bus.entrada_pronta = !cheio[bus.controle];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int x = 0; x < 2; x++) begin
        rd_q[x]  <= '0;
        wr_q[x]  <= '0;
        cnt_q[x] <= '0;
        for (int i = 0; i < PROFUNDIDADE; i++) begin
          mem_q[x][i] <= '0;
        end
      end
    end else begin
      for (int x = 0; x < 2; x++) begin
        rd_q[x]  <= rd_d[x];
        wr_q[x]  <= wr_d[x];
        cnt_q[x] <= cnt_d[x];
        if (push[x]) begin
          mem_q[x][wr_q[x]] <= bus.entrada;
        end
      end
    end
  end

  assign bus.saidaA        = mem_q[0][rd_q[0]];
  assign bus.saidaA_valida = (cnt_q[0] != '0);
  assign bus.ocupacaoA     = cnt_q[0];

  assign bus.saidaB        = mem_q[1][rd_q[1]];
  assign bus.saidaB_valida = (cnt_q[1] != '0);
  assign bus.ocupacaoB     = cnt_q[1];
endmodule
